// File: rtl/ram_pkg.sv
// Shared constants and parameter-legality helpers for the RAM family.
// Read-during-write modes and the supported read latencies live here so sibling RAMs agree.
package ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;

  typedef enum logic {
    RDW_E_OLD = 1'b0,
    RDW_E_NEW = 1'b1
  } rdw_mode_e;

  function automatic bit is_legal_latency(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

  function automatic bit is_legal_rdw(input int mode);
    return (mode == RDW_OLD) || (mode == RDW_NEW);
  endfunction

  function automatic bit is_legal_width(input int width);
    return (width > 0) && ((width % 8) == 0);
  endfunction

endpackage

// File: rtl/ram_rd_stage.sv
// One enable-gated read pipeline stage carrying {valid, err, data}.
// Data only reloads when a read passes through, so the last word is held between reads.
module ram_rd_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic                  i_err,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_err   <= i_valid & i_err;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_err   = r_err;
  assign o_data  = r_data;

endmodule

// File: rtl/ram_tp_be_pipe.sv
// Two-port RAM with byte write enables, 1- or 2-cycle pipelined read and selectable
// read-during-write behaviour. cen gates every register; out-of-range reads flag rerr.
module ram_tp_be_pipe
  import ram_pkg::*;
#(
  parameter  int DATA_WIDTH   = 32,
  parameter  int DEPTH        = 16,
  parameter  int READ_LATENCY = 1,
  parameter  int RDW_MODE     = 0,
  localparam int ADDR_WIDTH   = $clog2(DEPTH),
  localparam int BWEN_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cen,
  input  logic                  wen,
  input  logic [BWEN_WIDTH-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rerr
);

  if (!is_legal_width(DATA_WIDTH)) begin : g_bad_width
    $error("ram_tp_be_pipe: DATA_WIDTH must be a positive multiple of 8");
  end
  if (!is_legal_latency(READ_LATENCY)) begin : g_bad_latency
    $error("ram_tp_be_pipe: READ_LATENCY must be 1 or 2");
  end
  if (!is_legal_rdw(RDW_MODE)) begin : g_bad_rdw
    $error("ram_tp_be_pipe: RDW_MODE must be 0 or 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("ram_tp_be_pipe: DEPTH must be at least 2");
  end

  // One extra bit so a non-power-of-two DEPTH compares cleanly against the address.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_waddr_ok;
  logic                  w_raddr_ok;
  logic                  w_wr_ok;
  logic                  w_rd_acc;
  logic                  w_same_addr;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_rd_merged;
  logic [DATA_WIDTH-1:0] w_rd_sel;

  logic                  w_vld  [READ_LATENCY+1];
  logic                  w_err  [READ_LATENCY+1];
  logic [DATA_WIDTH-1:0] w_data [READ_LATENCY+1];

  assign w_waddr_ok  = ({1'b0, waddr} < DEPTH_W);
  assign w_raddr_ok  = ({1'b0, raddr} < DEPTH_W);
  assign w_wr_ok     = cen & wen & w_waddr_ok;
  assign w_rd_acc    = cen & ren;
  assign w_same_addr = w_wr_ok & (waddr == raddr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      for (int b = 0; b < BWEN_WIDTH; b++) begin
        if (wbe[b]) begin
          r_mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign w_rd_word = w_raddr_ok ? r_mem[raddr] : '0;

  // New-data bypass: bytes being written this cycle come straight from wdata.
  for (genvar gi = 0; gi < BWEN_WIDTH; gi++) begin : g_bypass
    assign w_rd_merged[8*gi +: 8] = (w_same_addr && wbe[gi]) ? wdata[8*gi +: 8]
                                                              : w_rd_word[8*gi +: 8];
  end

  assign w_rd_sel = (RDW_MODE == RDW_NEW) ? w_rd_merged : w_rd_word;

  assign w_vld[0]  = w_rd_acc;
  assign w_err[0]  = ~w_raddr_ok;
  assign w_data[0] = w_rd_sel;

  for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
    ram_rd_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .i_en    (cen),
      .i_valid (w_vld[gi]),
      .i_err   (w_err[gi]),
      .i_data  (w_data[gi]),
      .o_valid (w_vld[gi+1]),
      .o_err   (w_err[gi+1]),
      .o_data  (w_data[gi+1])
    );
  end

  assign rvalid = w_vld[READ_LATENCY];
  assign rerr   = w_err[READ_LATENCY];
  assign rdata  = w_data[READ_LATENCY];

endmodule

// File: tb/tb_ram_tp_be_pipe.sv
// Directed table-driven bench running two configurations side by side on shared stimulus:
// A = DEPTH 16, latency 1, old-data RDW; B = DEPTH 12, latency 2, new-data RDW.
module tb_ram_tp_be_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cen   = 1'b0;
  logic        wen   = 1'b0;
  logic [3:0]  wbe   = '0;
  logic [3:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        ren   = 1'b0;
  logic [3:0]  raddr = '0;

  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b, rerr_a, rerr_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ram_tp_be_pipe #(.DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(1), .RDW_MODE(0)) u_a (
    .clock(clock), .reset(reset), .cen(cen), .wen(wen), .wbe(wbe), .waddr(waddr),
    .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a), .rerr(rerr_a)
  );

  ram_tp_be_pipe #(.DATA_WIDTH(32), .DEPTH(12), .READ_LATENCY(2), .RDW_MODE(1)) u_b (
    .clock(clock), .reset(reset), .cen(cen), .wen(wen), .wbe(wbe), .waddr(waddr),
    .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b), .rerr(rerr_b)
  );

  typedef struct {
    logic        cen;
    logic        wen;
    logic [3:0]  wbe;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        ren;
    logic [3:0]  raddr;
    logic        av;
    logic        ae;
    logic [31:0] ad;
    logic        bv;
    logic        be;
    logic [31:0] bd;
  } vec_t;

  localparam int NV = 31;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic c, input logic w, input logic [3:0] m,
                              input logic [3:0] wa, input logic [31:0] wd,
                              input logic r, input logic [3:0] ra,
                              input logic av, input logic ae, input logic [31:0] ad,
                              input logic bv, input logic be, input logic [31:0] bd);
    vec_t v;
    v.cen = c; v.wen = w; v.wbe = m; v.waddr = wa; v.wdata = wd; v.ren = r; v.raddr = ra;
    v.av = av; v.ae = ae; v.ad = ad; v.bv = bv; v.be = be; v.bd = bd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic chk_all(input string tag, input logic av, input logic ae, input logic [31:0] ad,
                         input logic bv, input logic be, input logic [31:0] bd);
    chk({tag, " A rvalid"}, {31'd0, rvalid_a}, {31'd0, av});
    chk({tag, " A rerr"},   {31'd0, rerr_a},   {31'd0, ae});
    chk({tag, " A rdata"},  rdata_a, ad);
    chk({tag, " B rvalid"}, {31'd0, rvalid_b}, {31'd0, bv});
    chk({tag, " B rerr"},   {31'd0, rerr_b},   {31'd0, be});
    chk({tag, " B rdata"},  rdata_b, bd);
  endtask

  task automatic drive(input logic c, input logic w, input logic [3:0] m, input logic [3:0] wa,
                       input logic [31:0] wd, input logic r, input logic [3:0] ra);
    @(negedge clock);
    cen = c; wen = w; wbe = m; waddr = wa; wdata = wd; ren = r; raddr = ra;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Writes, partial bytes, RDW, out-of-range, wbe=0, boundary addresses.
    tbl[0]  = mk(1, 1, 4'hF, 4'd3,  32'hDEADBEEF, 0, 4'd0,  0, 0, 32'h0,        0, 0, 32'h0);
    tbl[1]  = mk(1, 0, 4'h0, 4'd0,  32'h0,        1, 4'd3,  1, 0, 32'hDEADBEEF, 0, 0, 32'h0);
    tbl[2]  = mk(1, 0, 4'h0, 4'd0,  32'h0,        0, 4'd0,  0, 0, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF);
    tbl[3]  = mk(1, 1, 4'hF, 4'd5,  32'h11223344, 0, 4'd0,  0, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
    tbl[4]  = mk(1, 1, 4'h5, 4'd5,  32'hAABBCCDD, 0, 4'd0,  0, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
    tbl[5]  = mk(1, 0, 4'h0, 4'd0,  32'h0,        1, 4'd5,  1, 0, 32'h11BB33DD, 0, 0, 32'hDEADBEEF);
    tbl[6]  = mk(1, 1, 4'hF, 4'd7,  32'h01234567, 0, 4'd0,  0, 0, 32'h11BB33DD, 1, 0, 32'h11BB33DD);
    tbl[7]  = mk(1, 1, 4'hF, 4'd7,  32'hCAFEF00D, 1, 4'd7,  1, 0, 32'h01234567, 0, 0, 32'h11BB33DD);
    tbl[8]  = mk(1, 1, 4'hF, 4'd13, 32'hFFFFFFFF, 1, 4'd13, 1, 0, 32'h0,        1, 0, 32'hCAFEF00D);
    tbl[9]  = mk(1, 0, 4'h0, 4'd0,  32'h0,        1, 4'd13, 1, 0, 32'hFFFFFFFF, 1, 1, 32'h0);
    tbl[10] = mk(1, 0, 4'h0, 4'd0,  32'h0,        1, 4'd0,  1, 0, 32'h0,        1, 1, 32'h0);
    tbl[11] = mk(1, 0, 4'h0, 4'd0,  32'h0,        0, 4'd0,  0, 0, 32'h0,        1, 0, 32'h0);
    tbl[12] = mk(1, 1, 4'h0, 4'd3,  32'h12345678, 0, 4'd0,  0, 0, 32'h0,        0, 0, 32'h0);
    tbl[13] = mk(1, 1, 4'hF, 4'd11, 32'h0A0B0C0D, 1, 4'd3,  1, 0, 32'hDEADBEEF, 0, 0, 32'h0);
    tbl[14] = mk(1, 0, 4'h0, 4'd0,  32'h0,        1, 4'd11, 1, 0, 32'h0A0B0C0D, 1, 0, 32'hDEADBEEF);
    tbl[15] = mk(1, 0, 4'h0, 4'd0,  32'h0,        1, 4'd12, 1, 0, 32'h0,        1, 0, 32'h0A0B0C0D);
    tbl[16] = mk(1, 0, 4'h0, 4'd0,  32'h0,        0, 4'd0,  0, 0, 32'h0,        1, 1, 32'h0);
    tbl[17] = mk(1, 0, 4'h0, 4'd0,  32'h0,        0, 4'd0,  0, 0, 32'h0,        0, 0, 32'h0);
    tbl[18] = mk(1, 1, 4'h3, 4'd7,  32'h11112222, 1, 4'd7,  1, 0, 32'hCAFEF00D, 0, 0, 32'h0);
    tbl[19] = mk(1, 0, 4'h0, 4'd0,  32'h0,        0, 4'd0,  0, 0, 32'hCAFEF00D, 1, 0, 32'hCAFE2222);
    // Consecutive reads of 0,1,2 with a two-cycle cen stall (and a blocked write) mid-stream.
    tbl[20] = mk(1, 1, 4'hF, 4'd0,  32'h00000100, 0, 4'd0,  0, 0, 32'hCAFEF00D, 0, 0, 32'hCAFE2222);
    tbl[21] = mk(1, 1, 4'hF, 4'd1,  32'h00000101, 0, 4'd0,  0, 0, 32'hCAFEF00D, 0, 0, 32'hCAFE2222);
    tbl[22] = mk(1, 1, 4'hF, 4'd2,  32'h00000102, 0, 4'd0,  0, 0, 32'hCAFEF00D, 0, 0, 32'hCAFE2222);
    tbl[23] = mk(1, 0, 4'h0, 4'd0,  32'h0,        1, 4'd0,  1, 0, 32'h00000100, 0, 0, 32'hCAFE2222);
    tbl[24] = mk(1, 0, 4'h0, 4'd0,  32'h0,        1, 4'd1,  1, 0, 32'h00000101, 1, 0, 32'h00000100);
    tbl[25] = mk(0, 1, 4'hF, 4'd2,  32'hDEAD0000, 1, 4'd2,  1, 0, 32'h00000101, 1, 0, 32'h00000100);
    tbl[26] = mk(0, 1, 4'hF, 4'd2,  32'hDEAD0000, 1, 4'd2,  1, 0, 32'h00000101, 1, 0, 32'h00000100);
    tbl[27] = mk(1, 0, 4'h0, 4'd0,  32'h0,        1, 4'd2,  1, 0, 32'h00000102, 1, 0, 32'h00000101);
    tbl[28] = mk(1, 0, 4'h0, 4'd0,  32'h0,        0, 4'd0,  0, 0, 32'h00000102, 1, 0, 32'h00000102);
    tbl[29] = mk(1, 0, 4'h0, 4'd0,  32'h0,        0, 4'd0,  0, 0, 32'h00000102, 0, 0, 32'h00000102);
    // Read accepted here; reset lands one cycle later while it is still in flight in B.
    tbl[30] = mk(1, 0, 4'h0, 4'd0,  32'h0,        1, 4'd0,  1, 0, 32'h00000100, 0, 0, 32'h00000102);

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    chk_all("reset", 0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].cen, tbl[i].wen, tbl[i].wbe, tbl[i].waddr, tbl[i].wdata,
            tbl[i].ren, tbl[i].raddr);
      chk_all($sformatf("row%0d", i), tbl[i].av, tbl[i].ae, tbl[i].ad,
              tbl[i].bv, tbl[i].be, tbl[i].bd);
    end

    // Reset mid-read: outputs clear immediately and nothing emerges after release.
    @(negedge clock);
    cen = 1'b1; wen = 1'b0; ren = 1'b0;
    reset = 1'b1;
    #1;
    chk_all("rst_async", 0, 0, 32'h0, 0, 0, 32'h0);
    @(posedge clock);
    #1;
    chk_all("rst_held", 0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk_all("rst_rel1", 0, 0, 32'h0, 0, 0, 32'h0);
    @(posedge clock);
    #1;
    chk_all("rst_rel2", 0, 0, 32'h0, 0, 0, 32'h0);

    // Every word reads back zero; B flags addresses 12..15 as out of range.
    for (int i = 0; i <= 16; i++) begin
      logic       b_v;
      logic       b_e;
      logic [3:0] ra;
      ra  = 4'(i);
      b_v = (i >= 1);
      b_e = (i >= 13);
      drive(1'b1, 1'b0, 4'h0, 4'd0, 32'h0, (i < 16), ra);
      chk_all($sformatf("clr%0d", i), (i < 16), 1'b0, 32'h0, b_v, b_e, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
